// File: rtl/button_conditioner.sv
// button_conditioner: N-channel pushbutton synchroniser/debouncer with edge pulses and a stretched CPU reset
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   btn_raw     raw, unsynchronised button pins
//   btn_db      debounced button levels
//   btn_press   one-cycle pulse on a debounced 0->1 edge
//   btn_release one-cycle pulse on a debounced 1->0 edge
//   cpu_rst     registered, stretched CPU reset driven by channel RST_BTN
module button_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int RST_BTN         = 3,
   parameter int RST_STRETCH     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             cpu_rst
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SW = RST_STRETCH > 0 ? $clog2(RST_STRETCH + 1) : 1;
   // Terminal values sit one below the threshold: the toggle happens on the edge that would reach it.
   localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] S_LAST = SW'(RST_STRETCH > 0 ? RST_STRETCH - 1 : 0);
   typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_t;
   logic [N_BTN-1:0] s1, s2;
   logic [CW-1:0]    cnt [N_BTN];
   state_t           state, state_n;
   logic [SW-1:0]    scnt, scnt_n;
   logic             cpu_rst_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1          <= '0;
         s2          <= '0;
         btn_db      <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         for (int i = 0; i < N_BTN; i++) begin
            btn_press[i]   <= 1'b0;
            btn_release[i] <= 1'b0;
            if (s2[i] == btn_db[i])
               cnt[i] <= '0;
            else if (cnt[i] == D_LAST) begin
               btn_db[i]      <= s2[i];
               btn_press[i]   <= s2[i];
               btn_release[i] <= ~s2[i];
               cnt[i]         <= '0;
            end else
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= HOLD;
         scnt    <= '0;
         cpu_rst <= 1'b1;
      end else begin
         state   <= state_n;
         scnt    <= scnt_n;
         cpu_rst <= cpu_rst_n;
      end
   always_comb begin
      state_n = state;
      scnt_n  = scnt;
      unique case (state)
         HOLD:
            if (!btn_db[RST_BTN]) begin
               state_n = RST_STRETCH == 0 ? RUN : STRETCH;
               scnt_n  = '0;
            end
         STRETCH:
            if (btn_db[RST_BTN])
               state_n = HOLD;
            else if (scnt == S_LAST) begin
               state_n = RUN;
               scnt_n  = '0;
            end else
               scnt_n = scnt + 1'b1;
         RUN:
            if (btn_press[RST_BTN]) state_n = HOLD;
         default:
            state_n = HOLD;
      endcase
   end
   // Registered from the next state so cpu_rst changes on the same edge as the FSM, glitch-free.
   always_comb cpu_rst_n = state_n != RUN;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scoreboard bench for button_conditioner
module tb_button_conditioner;
   typedef struct {
      int          cyc;
      logic [15:0] val;
   } ev_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] btn_raw = '0;
   logic [4:0] btn_db, btn_press, btn_release;
   logic       cpu_rst;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   ev_t        sb [$];
   logic [15:0] prev;
   logic [15:0] cur;
   button_conditioner #(
      .N_BTN(5), .DEBOUNCE_CYCLES(4), .RST_BTN(3), .RST_STRETCH(16)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_db(btn_db),
      .btn_press(btn_press), .btn_release(btn_release), .cpu_rst(cpu_rst)
   );
   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [15:0] mk(logic cr, logic [4:0] rl, logic [4:0] pr, logic [4:0] db);
      return {cr, rl, pr, db};
   endfunction
   task automatic push(int dk, logic [15:0] v);
      ev_t e;
      e.cyc = cyc + dk;
      e.val = v;
      sb.push_back(e);
   endtask
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic check_now(string name, logic [15:0] exp);
      cur = {cpu_rst, btn_release, btn_press, btn_db};
      checks++;
      if (cur !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, cur, exp);
      end
   endtask
   // Monitor: every change of the output vector must match the next scoreboard entry in time and value.
   initial prev = 16'h8000;
   always @(negedge clk) begin
      logic [15:0] v;
      ev_t e;
      v = {cpu_rst, btn_release, btn_press, btn_db};
      if (v !== prev) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: cyc %0d got %h, nothing expected", cyc, v);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.val !== v) begin
               errors++;
               $display("FAIL event: got cyc %0d out %h, expected cyc %0d out %h", cyc, v, e.cyc, e.val);
            end
         end
         prev = v;
      end
   end
   initial begin
      bit bounce [6];
      bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      #1 rst = 1'b1;
      step(5);
      check_now("reset_state", mk(1, 0, 0, 0));
      rst = 1'b0;
      push(17, mk(0, 0, 0, 0));
      step(20);
      btn_raw[0] = 1'b1;
      push(6, mk(0, 0, 5'h01, 5'h01));
      push(7, mk(0, 0, 0, 5'h01));
      step(10);
      btn_raw[0] = 1'b0;
      push(6, mk(0, 5'h01, 0, 0));
      push(7, mk(0, 0, 0, 0));
      step(10);
      for (int i = 0; i < 6; i++) begin
         btn_raw[1] = bounce[i];
         if (i == 5) begin
            push(6, mk(0, 0, 5'h02, 5'h02));
            push(7, mk(0, 0, 0, 5'h02));
         end
         step(1);
      end
      step(10);
      btn_raw[1] = 1'b0;
      push(6, mk(0, 5'h02, 0, 0));
      push(7, mk(0, 0, 0, 0));
      step(10);
      btn_raw[3] = 1'b1;
      push(6, mk(0, 0, 5'h08, 5'h08));
      push(7, mk(1, 0, 0, 5'h08));
      step(5);
      btn_raw[3] = 1'b0;
      push(6, mk(1, 5'h08, 0, 0));
      push(7, mk(1, 0, 0, 0));
      push(23, mk(0, 0, 0, 0));
      step(30);
      btn_raw[3] = 1'b1;
      step(3);
      btn_raw[3] = 1'b0;
      step(15);
      check_now("short_tap_no_reset", mk(0, 0, 0, 0));
      btn_raw[0] = 1'b1;
      btn_raw[4] = 1'b1;
      push(6, mk(0, 0, 5'h11, 5'h11));
      push(7, mk(0, 0, 0, 5'h11));
      step(10);
      rst = 1'b1;
      push(0, mk(1, 0, 0, 0));
      #1 check_now("mid_rst_instant_clear", mk(1, 0, 0, 0));
      step(3);
      rst = 1'b0;
      push(6, mk(1, 0, 5'h11, 5'h11));
      push(7, mk(1, 0, 0, 5'h11));
      push(17, mk(0, 0, 0, 5'h11));
      step(20);
      btn_raw[0] = 1'b0;
      btn_raw[4] = 1'b0;
      push(6, mk(0, 5'h11, 0, 0));
      push(7, mk(0, 0, 0, 0));
      step(12);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d events left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
